// File: rtl/video_pkg.sv
// Shared video geometry, pixel width and line-fill state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package video_pkg;

    localparam int NATIVE_HRES = 800;   // pixels per line, also the fill length
    localparam int NATIVE_VRES = 600;   // active lines per frame
    localparam int BITPERPIXEL = 12;    // pixel width
    localparam int ADDR_W      = 11;    // line index and pixel address width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_e;

endpackage

// File: rtl/line_fill_counter.sv
// Pixel counter for one line fill: clears to zero, counts accepted beats, saturates at LAST.
// Latency: count updates on the edge after i_en; o_last is combinational from the count.
// Backpressure: none of its own; the owner gates i_en with its handshake.
//
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   i_clr        restart the count at zero (wins over i_en)
//   i_en         one accepted beat this cycle
//   o_cnt        address of the next beat
//   o_last       the next beat is the final one of the line
module line_fill_counter #(
    parameter int W    = 11,
    parameter int LAST = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == W'(LAST));

    // Holding at LAST keeps the count from ever wrapping, even if a caller
    // keeps enabling after the final beat.
    always_ff @(posedge clk) begin
        if (!reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/line_fill_scheduler.sv
// Ping-pong line-buffer fill sequencer: requests the next line, streams its pixels into the idle bank.
// Latency: one cycle from an accepted pixel beat to its line-cache write strobe.
// Backpressure: req_valid held until req_ready; px_ready high only while filling, dropping after the last pixel.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   i_frame_start, i_line_start      timing-generator pulses
//   o_req_valid/i_req_ready/o_req_line   line request handshake to the source
//   i_px_valid/o_px_ready/i_px_data      pixel stream from the source
//   o_wr_en/o_wr_bank/o_wr_addr/o_wr_data line-cache write port
//   o_rd_bank, o_disp_line           bank and line scanout must use
//   o_underrun, o_busy               late-fill pulse, request/fill in progress
module line_fill_scheduler
    import video_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_frame_start,
    input  logic                   i_line_start,
    output logic                   o_req_valid,
    input  logic                   i_req_ready,
    output logic [ADDR_W-1:0]      o_req_line,
    input  logic                   i_px_valid,
    output logic                   o_px_ready,
    input  logic [BITPERPIXEL-1:0] i_px_data,
    output logic                   o_wr_en,
    output logic                   o_wr_bank,
    output logic [ADDR_W-1:0]      o_wr_addr,
    output logic [BITPERPIXEL-1:0] o_wr_data,
    output logic                   o_rd_bank,
    output logic [ADDR_W-1:0]      o_disp_line,
    output logic                   o_underrun,
    output logic                   o_busy
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_FILL = ST_FILL;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]             r_state;
    logic                   r_fill_bank;
    logic                   r_ready_flag;
    logic [ADDR_W-1:0]      r_next_line;
    logic                   r_rd_bank;
    logic [ADDR_W-1:0]      r_disp_line;
    logic                   r_underrun;
    logic                   r_wr_en;
    logic                   r_wr_bank;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [BITPERPIXEL-1:0] r_wr_data;

    logic                   w_last_line;
    logic                   w_ls_take;
    logic                   w_beat;
    logic                   w_pix_clr;
    logic                   w_pix_last;
    logic [ADDR_W-1:0]      w_pix_cnt;

    assign w_last_line = (r_next_line == ADDR_W'(NATIVE_VRES - 1));

    // IDLE with the last line already handed over means the frame is finished:
    // further line_starts are dropped silently. IDLE straight out of reset
    // still has next_line at 0, so a line_start there counts as a missed prefetch.
    assign w_ls_take = i_line_start && !i_frame_start && !((r_state == S_IDLE) && w_last_line);

    // A beat coinciding with an abort is not written.
    assign w_beat    = (r_state == S_FILL) && i_px_valid && !i_frame_start && !w_ls_take;
    assign w_pix_clr = i_frame_start || w_ls_take;

    line_fill_counter #(
        .W    (ADDR_W),
        .LAST (NATIVE_HRES - 1)
    ) u_pix_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_pix_clr),
        .i_en   (w_beat),
        .o_cnt  (w_pix_cnt),
        .o_last (w_pix_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_fill_bank  <= 1'b0;
            r_ready_flag <= 1'b0;
            r_next_line  <= '0;
            r_rd_bank    <= 1'b0;
            r_disp_line  <= '0;
            r_underrun   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en    <= 1'b0;
            r_underrun <= 1'b0;
            if (i_frame_start) begin
                r_state      <= S_REQ;
                r_fill_bank  <= 1'b0;
                r_next_line  <= '0;
                r_ready_flag <= 1'b0;
                r_disp_line  <= '0;
            end else if (w_ls_take) begin
                if (r_ready_flag) begin
                    r_rd_bank   <= r_fill_bank;
                    r_fill_bank <= ~r_fill_bank;
                end else begin
                    // Late fill: scanout keeps the old bank and the refill
                    // goes back into the same bank for the following line.
                    r_underrun <= 1'b1;
                end
                r_disp_line  <= r_next_line;
                r_ready_flag <= 1'b0;
                if (w_last_line) begin
                    r_state <= S_IDLE;
                end else begin
                    r_next_line <= r_next_line + 1'b1;
                    r_state     <= S_REQ;
                end
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (i_req_ready) begin
                            r_state <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (w_beat) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_pix_cnt;
                            r_wr_data <= i_px_data;
                            r_wr_bank <= r_fill_bank;
                            if (w_pix_last) begin
                                r_state      <= S_DONE;
                                r_ready_flag <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_req_valid = (r_state == S_REQ);
    assign o_req_line  = r_next_line;
    assign o_px_ready  = (r_state == S_FILL);
    assign o_busy      = (r_state == S_REQ) || (r_state == S_FILL);
    assign o_wr_en     = r_wr_en;
    assign o_wr_bank   = r_wr_bank;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_rd_bank   = r_rd_bank;
    assign o_disp_line = r_disp_line;
    assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_line_fill_scheduler.sv
// Self-checking bench for line_fill_scheduler: vector table, directed line/frame sequences, random traffic.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: source handshakes driven by the bench (directed stalls and random).
module tb_line_fill_scheduler;
    import video_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset       = 1'b0;
    logic                   frame_start = 1'b0;
    logic                   line_start  = 1'b0;
    logic                   req_ready   = 1'b0;
    logic                   px_valid    = 1'b0;
    logic [BITPERPIXEL-1:0] px_data     = '0;

    logic                   o_req_valid;
    logic [ADDR_W-1:0]      o_req_line;
    logic                   o_px_ready;
    logic                   o_wr_en;
    logic                   o_wr_bank;
    logic [ADDR_W-1:0]      o_wr_addr;
    logic [BITPERPIXEL-1:0] o_wr_data;
    logic                   o_rd_bank;
    logic [ADDR_W-1:0]      o_disp_line;
    logic                   o_underrun;
    logic                   o_busy;

    line_fill_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (frame_start),
        .i_line_start  (line_start),
        .o_req_valid   (o_req_valid),
        .i_req_ready   (req_ready),
        .o_req_line    (o_req_line),
        .i_px_valid    (px_valid),
        .o_px_ready    (o_px_ready),
        .i_px_data     (px_data),
        .o_wr_en       (o_wr_en),
        .o_wr_bank     (o_wr_bank),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_rd_bank     (o_rd_bank),
        .o_disp_line   (o_disp_line),
        .o_underrun    (o_underrun),
        .o_busy        (o_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output snapshot; request line only matters while requesting and write
    // fields only while strobing, except under reset where everything must be 0.
    function automatic logic [63:0] pk(input logic rv, input logic [10:0] rl, input logic pr,
                                       input logic we, input logic wb, input logic [10:0] wa,
                                       input logic [11:0] wd, input logic rb, input logic [10:0] dl,
                                       input logic und, input logic bsy, input logic full);
        logic sw;
        logic sr;
        sw = we | full;
        sr = rv | full;
        return {12'd0, rv, sr ? rl : 11'd0, pr, we, sw ? wb : 1'b0, sw ? wa : 11'd0,
                sw ? wd : 12'd0, rb, dl, und, bsy};
    endfunction

    function automatic logic [63:0] dut_pk(input logic full);
        return pk(o_req_valid, o_req_line, o_px_ready, o_wr_en, o_wr_bank, o_wr_addr, o_wr_data,
                  o_rd_bank, o_disp_line, o_underrun, o_busy, full);
    endfunction

    // ---------------- behavioural reference model ----------------
    localparam int P_IDLE = 0, P_REQ = 1, P_FILL = 2, P_DONE = 3;
    int m_phase = P_IDLE;
    bit m_fbank, m_ready, m_rbank, m_wen, m_wbank, m_und, m_frame_over;
    int m_next, m_disp, m_pix, m_waddr, m_wdata;

    task automatic model_edge();
        m_wen = 0;
        m_und = 0;
        if (!reset) begin
            m_phase = P_IDLE; m_fbank = 0; m_ready = 0; m_rbank = 0; m_wbank = 0;
            m_next = 0; m_disp = 0; m_pix = 0; m_waddr = 0; m_wdata = 0; m_frame_over = 0;
        end else if (frame_start) begin
            m_fbank = 0; m_next = 0; m_ready = 0; m_disp = 0; m_pix = 0;
            m_frame_over = 0; m_phase = P_REQ;
        end else if (line_start && !m_frame_over) begin
            if (m_ready) begin
                m_rbank = m_fbank;
                m_fbank = !m_fbank;
            end else begin
                m_und = 1;
            end
            m_disp  = m_next;
            m_ready = 0;
            m_pix   = 0;
            if (m_next >= NATIVE_VRES - 1) begin
                m_phase = P_IDLE;
                m_frame_over = 1;
            end else begin
                m_next  = m_next + 1;
                m_phase = P_REQ;
            end
        end else if (m_phase == P_REQ) begin
            if (req_ready) m_phase = P_FILL;
        end else if (m_phase == P_FILL && px_valid) begin
            m_wen = 1; m_waddr = m_pix; m_wdata = int'(px_data); m_wbank = m_fbank;
            if (m_pix == NATIVE_HRES - 1) begin
                m_phase = P_DONE;
                m_ready = 1;
            end else begin
                m_pix = m_pix + 1;
            end
        end
    endtask

    function automatic logic [63:0] mdl_pk(input logic full);
        return pk(m_phase == P_REQ, 11'(m_next), m_phase == P_FILL, m_wen, m_wbank, 11'(m_waddr),
                  12'(m_wdata), m_rbank, 11'(m_disp), m_und,
                  (m_phase == P_REQ) || (m_phase == P_FILL), full);
    endfunction

    int n_wr = 0, seq_err = 0, n_und = 0;
    bit last_wb = 0;

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check("model", dut_pk(!reset), mdl_pk(!reset));
        if (o_wr_en) begin
            if (o_wr_addr != 11'(n_wr)) seq_err++;
            n_wr++;
            last_wb = o_wr_bank;
        end
        if (o_underrun) n_und++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic rst, fs, ls, rr, pv; logic [11:0] pd;
        logic rv; logic [10:0] rl; logic pr, we, wb; logic [10:0] wa; logic [11:0] wd;
        logic rb; logic [10:0] dl; logic und, bsy;
    } vec_t;
    vec_t tbl[14];

    initial begin
        //          rst fs ls rr pv pd       rv rl  pr we wb wa wd       rb dl und bsy
        tbl[0]  = '{0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0, 12'h000, 1, 1, 0, 0, 0, 0, 12'h000, 0, 0, 1, 1};
        tbl[2]  = '{1, 1, 0, 0, 0, 12'h000, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 0, 12'h000, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 1, 0, 12'h000, 0, 0, 1, 0, 0, 0, 12'h000, 0, 0, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 1, 12'hABC, 0, 0, 1, 1, 0, 0, 12'hABC, 0, 0, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 12'h000, 0, 0, 1, 0, 0, 0, 12'h000, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 0, 1, 12'h123, 0, 0, 1, 1, 0, 1, 12'h123, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 1, 0, 1, 12'h456, 1, 1, 0, 0, 0, 0, 12'h000, 0, 0, 1, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 12'h000, 1, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 1, 1, 0, 12'h000, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1};
        tbl[11] = '{1, 0, 0, 1, 0, 12'h000, 0, 0, 1, 0, 0, 0, 12'h000, 0, 0, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 1, 12'h007, 0, 0, 1, 1, 0, 0, 12'h007, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; frame_start = tbl[i].fs; line_start = tbl[i].ls;
            req_ready = tbl[i].rr; px_valid = tbl[i].pv; px_data = tbl[i].pd;
            cyc();
            check($sformatf("vec%0d", i), dut_pk(!tbl[i].rst),
                  pk(tbl[i].rv, tbl[i].rl, tbl[i].pr, tbl[i].we, tbl[i].wb, tbl[i].wa, tbl[i].wd,
                     tbl[i].rb, tbl[i].dl, tbl[i].und, tbl[i].bsy, !tbl[i].rst));
        end

        // Line 0 prefetch, source never stalls, data equals address.
        reset = 1; frame_start = 1; line_start = 0; req_ready = 1; px_valid = 1; px_data = '0;
        cyc();
        frame_start = 0;
        check("s1_req", {o_req_valid, o_req_line}, {1'b1, 11'd0});
        n_wr = 0; seq_err = 0;
        for (int k = 0; k < 1000; k++) begin
            px_data = 12'(m_pix);
            cyc();
            if (!o_busy) break;
        end
        check("s1_done", o_busy, 0);
        check("s1_nwr", n_wr, NATIVE_HRES);
        check("s1_seq", seq_err, 0);
        check("s1_bank", last_wb, 0);

        // First swap: display line 0 from bank 0, request line 1.
        req_ready = 0; px_valid = 0;
        line_start = 1; cyc(); line_start = 0;
        check("s2_rd_bank", o_rd_bank, 0);
        check("s2_disp", o_disp_line, 0);
        check("s2_req", {o_req_valid, o_req_line}, {1'b1, 11'd1});
        check("s2_und", o_underrun, 0);

        // Stalled source: request held 5 cycles, pixels every other cycle.
        begin
            int unstable;
            unstable = 0;
            for (int k = 0; k < 5; k++) begin
                cyc();
                if (!o_req_valid || o_req_line != 11'd1) unstable++;
            end
            check("s3_req_hold", unstable, 0);
        end
        req_ready = 1; cyc(); req_ready = 0;
        n_wr = 0; seq_err = 0;
        for (int k = 0; k < 2500; k++) begin
            px_valid = (k % 2 == 0);
            px_data = 12'($urandom);
            cyc();
            if (!o_busy) break;
        end
        px_valid = 0;
        check("s3_done", o_busy, 0);
        check("s3_nwr", n_wr, NATIVE_HRES);
        check("s3_seq", seq_err, 0);
        check("s3_bank", last_wb, 1);
        line_start = 1; cyc(); line_start = 0;
        check("s3_rd_bank", o_rd_bank, 1);
        check("s3_disp", o_disp_line, 1);
        check("s3_req", {o_req_valid, o_req_line}, {1'b1, 11'd2});

        // Late fill: line_start after 400 pixels of line 2.
        req_ready = 1; cyc(); req_ready = 0;
        n_wr = 0; px_valid = 1;
        for (int k = 0; k < 400; k++) begin
            px_data = 12'($urandom);
            cyc();
        end
        check("s4_partial", n_wr, 400);
        line_start = 1; cyc(); line_start = 0;
        check("s4_und", o_underrun, 1);
        check("s4_rd_bank", o_rd_bank, 1);
        check("s4_no_wr_abort", o_wr_en, 0);
        check("s4_disp", o_disp_line, 2);
        check("s4_req", {o_req_valid, o_req_line}, {1'b1, 11'd3});
        n_wr = 0;
        cyc();
        check("s4_und_pulse", o_underrun, 0);
        for (int k = 0; k < 3; k++) cyc();
        check("s4_no_wr_req", n_wr, 0);
        req_ready = 1; cyc(); req_ready = 0;
        n_wr = 0; seq_err = 0;
        for (int k = 0; k < 3; k++) begin
            px_data = 12'($urandom);
            cyc();
        end
        check("s4_refill", n_wr, 3);
        check("s4_same_bank", last_wb, 0);
        check("s4_seq", seq_err, 0);

        // Whole frame of line_starts with no fills: all underruns, then IDLE.
        px_valid = 0;
        frame_start = 1; cyc(); frame_start = 0;
        n_und = 0;
        for (int k = 0; k < NATIVE_VRES; k++) begin
            line_start = 1; cyc(); line_start = 0; cyc();
        end
        check("s5_und_count", n_und, NATIVE_VRES);
        check("s5_idle", {o_busy, o_req_valid}, 2'b00);
        check("s5_disp", o_disp_line, NATIVE_VRES - 1);
        line_start = 1; cyc(); line_start = 0;
        check("s5_extra_und", o_underrun, 0);
        for (int k = 0; k < 3; k++) cyc();
        check("s5_extra_req", {o_busy, o_req_valid}, 2'b00);

        // frame_start + line_start together mid-fill, then reset mid-fill.
        frame_start = 1; req_ready = 1; cyc(); frame_start = 0;
        cyc();
        req_ready = 0; px_valid = 1;
        for (int k = 0; k < 10; k++) cyc();
        frame_start = 1; line_start = 1; cyc(); frame_start = 0; line_start = 0;
        check("s6_und", o_underrun, 0);
        check("s6_req", {o_req_valid, o_req_line}, {1'b1, 11'd0});
        check("s6_wr", o_wr_en, 0);
        req_ready = 1; cyc(); req_ready = 0;
        for (int k = 0; k < 5; k++) cyc();
        reset = 0; cyc();
        check("s6_reset", dut_pk(1'b1), 64'd0);
        reset = 1; n_wr = 0;
        for (int k = 0; k < 5; k++) cyc();
        check("s6_no_wr", n_wr, 0);
        check("s6_idle", o_busy, 0);

        // Random traffic against the model.
        frame_start = 1; cyc(); frame_start = 0;
        for (int k = 0; k < 30000; k++) begin
            reset       = ($urandom_range(0, 9999) != 0);
            frame_start = ($urandom_range(0, 4999) == 0);
            line_start  = ($urandom_range(0, 899) == 0);
            req_ready   = $urandom_range(0, 1);
            px_valid    = ($urandom_range(0, 3) != 0);
            px_data     = 12'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_fill_scheduler.md
Name: line_fill_scheduler

Overview:
Sequences a ping-pong pair of line buffers between the upstream pixel source (frame store / stream) and the scanout line cache. While scanout reads one bank, the block requests the next line, accepts its pixels over a valid/ready stream, and writes them into the other bank. Bank swap happens at each line start. The block flags underrun when a fill is late. It sits between the frame-store reader and the line-cache RAM, driven by the video timing generator.

Parameters:
NATIVE_HRES, 800, pixels per line; fill length
NATIVE_VRES, 600, active lines per frame
BITPERPIXEL, 12, pixel width
ADDR_W, 11, width of line index and pixel address

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
frame_start  input  1  one-cycle pulse, vertical blanking start; prefetch line 0
line_start  input  1  one-cycle pulse before each active line's scanout
req_valid  output  1  line request valid to source
req_ready  input  1  source accepts request
req_line  output  ADDR_W  requested line index
px_valid  input  1  source pixel valid
px_ready  output  1  scheduler accepts pixel
px_data  input  BITPERPIXEL  source pixel
wr_en  output  1  line-cache write strobe
wr_bank  output  1  bank being written
wr_addr  output  ADDR_W  pixel address within line
wr_data  output  BITPERPIXEL  pixel to write
rd_bank  output  1  bank scanout must read
disp_line  output  ADDR_W  line currently displayed
underrun  output  1  one-cycle pulse, late fill detected
busy  output  1  high in REQ or FILL

Behaviour:
- Reset (reset==0 at clk edge): state IDLE. All outputs 0: req_valid, req_line, px_ready, wr_en, wr_bank, wr_addr, wr_data, rd_bank, disp_line, underrun, busy. Internal fill_bank=0, pix_cnt=0, ready_flag=0, next_line=0. Reset mid-fill aborts with no further writes.
- States: IDLE, REQ, FILL, DONE.
- IDLE: waits for frame_start or line_start.
- REQ: req_valid=1 and req_line=next_line, held stable until the cycle with req_ready=1. Then go to FILL with pix_cnt=0.
- FILL: px_ready=1. Each px_valid&&px_ready beat registers the write: wr_en=1 on the next cycle, with wr_addr=pix_cnt, wr_data=px_data, wr_bank=fill_bank. Write latency is 1 cycle. pix_cnt then increments. The beat with pix_cnt==NATIVE_HRES-1 moves the block to DONE and sets ready_flag=1. px_ready drops in the cycle after that beat. No pixel beyond NATIVE_HRES is accepted.
- DONE: idle until the next line_start or frame_start.
- frame_start, in any state: abort any request or fill. Set fill_bank=0, next_line=0, ready_flag=0, disp_line=0, then go to REQ. No underrun is raised.
- line_start with ready_flag=1:
  - rd_bank<=fill_bank and fill_bank<=~fill_bank.
  - disp_line<=next_line; ready_flag<=0.
  - If next_line<NATIVE_VRES-1: next_line+1, go to REQ. Otherwise go to IDLE, with no request past the last line.
- line_start with ready_flag=0 (fill late, or no prefetch):
  - underrun pulses for 1 cycle.
  - No bank swap; scanout repeats the previous bank. disp_line still advances to next_line.
  - The current request/fill is aborted: req_valid drops, px_ready drops, and no further wr_en for it.
  - next_line<=next_line+1 if below NATIVE_VRES-1, and fill restarts in REQ into the same fill_bank. At the last line, go to IDLE.
- Simultaneous frame_start and line_start: frame_start wins and line_start is ignored.
- line_start in IDLE after the last line: ignored, no underrun.
- busy=1 iff state in {REQ, FILL}.
- Counters are ADDR_W bits and never wrap. pix_cnt is bounded by NATIVE_HRES-1, next_line by NATIVE_VRES-1.

Decomposition:
- Shared package video_pkg: NATIVE_HRES, NATIVE_VRES, BITPERPIXEL, ADDR_W, and the state enum {IDLE, REQ, FILL, DONE}.
- One natural sub-module, line_fill_counter: pix_cnt with clear/enable/last output, also reusable by the frame-store reader.

Test Plan:
1. Release reset, pulse frame_start, req_ready=1 immediately, px_valid=1 continuously with px_data=addr -> req_line=0. wr_en asserts 800 cycles with wr_bank=0 and wr_addr 0..799, then DONE with busy=0.
2. After scenario 1, pulse line_start -> next cycle rd_bank=0, disp_line=0, req_line=1, fill into bank 1. After a second line_start -> rd_bank=1.
3. Source stalls: px_valid toggling 1/0 and req_ready delayed 5 cycles -> req_line stays stable while waiting. Exactly 800 writes occur, with wr_addr strictly sequential and no gaps.
4. Line_start arrives after only 400 pixels -> underrun for 1 cycle, rd_bank unchanged, no wr_en after abort, new request for the following line into the same bank.
5. Run a full frame of 600 line_starts -> after line 599 the block is IDLE with no request issued. An extra line_start gives no underrun.
6. frame_start and line_start in the same cycle mid-FILL, then reset mid-FILL -> the block restarts with req_line=0 and no underrun. Reset returns all outputs to 0 on the next edge.
